// File: rtl/leitor_de_registradores.sv
// rtl/leitor_de_registradores.sv - register-file range reader streaming words over valid/ready (optional checksum: LEITOR_CHECKSUM_EN)
module leitor_de_registradores #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_SEND,
        ST_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_acc;
    logic              xfer;

    // Next-state logic: one READ cycle samples the bank, SEND waits for the consumer.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        start_acc   = 1'b0;
        xfer        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_d     = first_reg;
                    last_d    = last_reg;
                    start_acc = 1'b1;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                out_data_d  = rd_data;
                out_index_d = cur_q;
                out_valid_d = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (out_valid_q && out_ready) begin
                    xfer        = 1'b1;
                    out_valid_d = 1'b0;
                    if (cur_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        // Natural ADDR_W-bit overflow gives the 31 -> 0 wrap for reversed ranges.
                        cur_d   = cur_q + ADDR_W'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State registers; reset takes priority over any start request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr   = cur_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef LEITOR_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    // Running sum of accepted words, restarted by each accepted start.
    always_comb begin
        checksum_d = checksum_q;
        if (start_acc) begin
            checksum_d = '0;
        end else if (xfer) begin
            checksum_d = checksum_q + out_data_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_cks;
    assign unused_cks = start_acc | xfer;
    assign checksum   = '0;
`endif

endmodule

// File: tb/tb_leitor_de_registradores.sv
// tb/tb_leitor_de_registradores.sv - directed scoreboard bench for leitor_de_registradores
module tb_leitor_de_registradores;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [31:0] rd_data;
    logic [4:0]  rd_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    logic [31:0] bank [32];
    logic [36:0] sb [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rd_data = bank[rd_addr];

    leitor_de_registradores #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rd_data   (rd_data),
        .rd_addr   (rd_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every accepted word is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", {27'd0, out_index, out_data}, 64'hDEAD);
            end else begin
                chk("word", {27'd0, out_index, out_data}, {27'd0, sb.pop_front()});
            end
        end
    end

    task automatic push_range(input logic [4:0] f, input logic [4:0] l,
                              output int k, output logic [31:0] sum);
        logic [4:0] d;
        logic [4:0] idx;
        d   = l - f;
        k   = int'(d) + 1;
        sum = '0;
        idx = f;
        for (int i = 0; i < k; i++) begin
            sb.push_back({idx, bank[idx]});
            sum = sum + bank[idx];
            idx = idx + 5'd1;
        end
    endtask

    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input bit poke);
        int          k;
        int          cyc;
        logic [31:0] sum;
        push_range(f, l, k, sum);
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        cyc       = 0;
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                first_reg = f + 5'd9;
                last_reg  = f + 5'd9;
            end
            if (poke && cyc == 3) begin
                start = 1'b1;
                first_reg = f + 5'd3;
                last_reg  = f + 5'd7;
            end
            if (poke && cyc == 4) start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
        chk("done_latency", 64'(cyc), 64'(2 * k + 1));
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
`ifdef LEITOR_CHECKSUM_EN
        chk("checksum", {32'd0, checksum}, {32'd0, sum});
`else
        chk("checksum", {32'd0, checksum}, 64'd0);
`endif
        @(posedge clk); #1;
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("busy_after_finish", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int          cyc;
        logic [31:0] hold_data;
        logic [4:0]  hold_idx;
        for (int i = 0; i < 32; i++) bank[i] = {16'hC0DE, 11'd0, 5'(i)};
        bank[0]  = 32'h0;
        bank[1]  = 32'hB;
        bank[2]  = 32'h0000_0005;
        bank[3]  = 32'hFFFF_FFFF;
        bank[4]  = 32'h1234_5678;
        bank[31] = 32'hA;

        reset = 1'b1; start = 1'b0; out_ready = 1'b1; first_reg = '0; last_reg = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_addr", {59'd0, rd_addr}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_index", {59'd0, out_index}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_checksum", {32'd0, checksum}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Range 2..4, with a stray start pulse mid-dump that must be ignored.
        run_dump(5'd2, 5'd4, 1'b1);
        // Single register and wrap-around range.
        run_dump(5'd0, 5'd0, 1'b0);
        run_dump(5'd31, 5'd1, 1'b0);
        // Full range.
        run_dump(5'd0, 5'd31, 1'b0);

        // Backpressure on the second word of 10..13.
        begin
            int          k;
            logic [31:0] sum;
            push_range(5'd10, 5'd13, k, sum);
            first_reg = 5'd10; last_reg = 5'd13; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            cyc = 0;
            while (!(out_valid && out_index == 5'd11) && cyc < 50) begin
                @(posedge clk); #1; cyc++;
            end
            chk("bp_reach_word2", 64'(cyc < 50), 64'd1);
            out_ready = 1'b0;
            hold_data = out_data; hold_idx = out_index;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                chk("bp_valid_held", {63'd0, out_valid}, 64'd1);
                chk("bp_data_stable", {27'd0, out_index, out_data}, {27'd0, hold_idx, hold_data});
            end
            out_ready = 1'b1;
            cyc = 0;
            while (!done && cyc < 50) begin
                @(posedge clk); #1; cyc++;
            end
            chk("bp_done_seen", {63'd0, done}, 64'd1);
            chk("bp_scoreboard_empty", 64'(sb.size()), 64'd0);
            @(posedge clk); #1;
        end

        // Reset during SEND of word 2 of 0..7.
        begin
            int          k;
            logic [31:0] sum;
            push_range(5'd0, 5'd7, k, sum);
            first_reg = 5'd0; last_reg = 5'd7; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            cyc = 0;
            while (!(out_valid && out_index == 5'd1) && cyc < 50) begin
                @(posedge clk); #1; cyc++;
            end
            chk("mr_reach_word2", 64'(cyc < 50), 64'd1);
            reset = 1'b1; out_ready = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            sb.delete();
            chk("mr_out_valid", {63'd0, out_valid}, 64'd0);
            chk("mr_busy", {63'd0, busy}, 64'd0);
            for (int i = 0; i < 5; i++) begin
                chk("mr_no_done", {63'd0, done}, 64'd0);
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            run_dump(5'd5, 5'd6, 1'b0);
        end

        // start together with reset must be dropped.
        reset = 1'b1; start = 1'b1; first_reg = 5'd3; last_reg = 5'd4;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        chk("sr_busy", {63'd0, busy}, 64'd0);
        chk("sr_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk("sr_stay_idle", {63'd0, busy}, 64'd0);
        chk("sr_rd_addr", {59'd0, rd_addr}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
